// File: rtl/mux_pkg.sv
// Shared constants, skid-stage state encoding and helpers for the N:1 registered selector.
package mux_pkg;

  localparam int unsigned NUM_IN_MAX = 16;

  // Encoding is {skid_valid, out_valid}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StFull  = 2'b11
  } skid_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry valid/ready register stage: main output register plus one skid register.
// in_ready_o is derived purely from state, so there is no combinational path from out_ready_i.
module pipe_skid_buf
  import mux_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept;
  logic              drain;

  assign in_ready_o  = (state_q != StFull);
  assign out_valid_o = (state_q != StEmpty);
  assign out_data_o  = main_q;
  assign accept      = in_valid_i && in_ready_o;
  assign drain       = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) begin
          main_d  = in_data_i;
          state_d = StOne;
        end
      end
      StOne: begin
        if (accept && drain) begin
          main_d = in_data_i;
        end else if (accept) begin
          skid_d  = in_data_i;
          state_d = StFull;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          main_d  = skid_q;
          state_d = StOne;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// Parametrised N:1 selector feeding a registered skid stage; out-of-range select forwards zeros.
// Optional sticky out-of-range flag sel_err_o is enabled by defining MUX_SEL_ERR_EN.
module mux_nto1_pipe
  import mux_pkg::*;
#(
  parameter int unsigned  DATA_W = 32,
  parameter int unsigned  NUM_IN = 4,
  localparam int unsigned SEL_W  = clog2(NUM_IN)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_IN*DATA_W-1:0] data_i,
  input  logic [SEL_W-1:0]         select_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     out_valid_o,
`ifdef MUX_SEL_ERR_EN
  output logic                     sel_err_o,
`endif
  input  logic                     out_ready_i
);

  logic [DATA_W-1:0] sel_data;

  // Indices with no matching input fall through to the all-zero default.
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (select_i == SEL_W'(k)) begin
        sel_data = data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  pipe_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (sel_data),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

`ifdef MUX_SEL_ERR_EN
  if ((NUM_IN & (NUM_IN - 1)) == 0) begin : g_sel_err_tie
    // Every select code maps to a real input.
    assign sel_err_o = 1'b0;
  end else begin : g_sel_err
    logic sel_err_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sel_err_q <= 1'b0;
      end else if (in_valid_i && in_ready_o && (int'(select_i) >= int'(NUM_IN))) begin
        sel_err_q <= 1'b1;
      end
    end
    assign sel_err_o = sel_err_q;
  end
`endif

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Scoreboard bench for mux_nto1_pipe: a 4-input instance for streaming/back-pressure/random
// traffic and a 3-input instance for out-of-range select handling.
module tb_mux_nto1_pipe;

  localparam int unsigned DW = 32;
  localparam int unsigned N4 = 4;
  localparam int unsigned N3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic [N4*DW-1:0] data      = '0;
  logic [1:0]       sel       = '0;
  logic             in_valid  = 1'b0;
  logic             in_ready;
  logic [DW-1:0]    dout;
  logic             out_valid;
  logic             out_ready = 1'b0;

  logic [N3*DW-1:0] data3      = '0;
  logic [1:0]       sel3       = '0;
  logic             in_valid3  = 1'b0;
  logic             in_ready3;
  logic [DW-1:0]    dout3;
  logic             out_valid3;
  logic             out_ready3 = 1'b1;

`ifdef MUX_SEL_ERR_EN
  logic sel_err;
  logic sel_err3;
`endif

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mux_nto1_pipe #(
    .DATA_W (DW),
    .NUM_IN (N4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (data),
    .select_i    (sel),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .data_o      (dout),
    .out_valid_o (out_valid),
`ifdef MUX_SEL_ERR_EN
    .sel_err_o   (sel_err),
`endif
    .out_ready_i (out_ready)
  );

  mux_nto1_pipe #(
    .DATA_W (DW),
    .NUM_IN (N3)
  ) dut3 (
    .clk_i       (clk),
    .rst_i       (rst),
    .data_i      (data3),
    .select_i    (sel3),
    .in_valid_i  (in_valid3),
    .in_ready_o  (in_ready3),
    .data_o      (dout3),
    .out_valid_o (out_valid3),
`ifdef MUX_SEL_ERR_EN
    .sel_err_o   (sel_err3),
`endif
    .out_ready_i (out_ready3)
  );

  // Reference selection: word s of the packed vector, or zero past the last input.
  function automatic logic [DW-1:0] ref_sel(input logic [N4*DW-1:0] d, input int unsigned s,
                                            input int unsigned n);
    if (s >= n) return '0;
    return d[s*DW +: DW];
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of input; the model records the beat only if the stage can take it.
  task automatic drive(input logic v, input logic [1:0] s);
    in_valid = v;
    sel      = s;
    if (v && in_ready) exp_q.push_back(ref_sel(data, int'(s), N4));
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_beat: got %h expected none", dout);
      end else begin
        check("scoreboard", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [1:0]    seq[4];
    logic [DW-1:0] stream_exp[4];
    logic [DW-1:0] exp_a, exp_b, exp_c;
    int sent, cyc_n;
    logic v;
    logic [1:0] s;

    seq        = '{2'd2, 2'd0, 2'd3, 2'd1};
    stream_exp = '{32'h22, 32'h00, 32'h33, 32'h11};

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data", dout, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst3_out_valid", 32'(out_valid3), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    cyc();

    // Streaming at full rate.
    data      = {32'h33, 32'h22, 32'h11, 32'h00};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, seq[i]);
      cyc();
      check("stream_valid", 32'(out_valid), 32'd1);
      check("stream_data", dout, stream_exp[i]);
    end
    drive(1'b0, 2'd0);
    cyc();
    cyc();

    // Back-pressure: fill main and skid, hold, then drain.
    out_ready = 1'b0;
    data = {$urandom, $urandom, $urandom, $urandom};
    exp_a = ref_sel(data, 1, N4);
    drive(1'b1, 2'd1);
    cyc();
    data = {$urandom, $urandom, $urandom, $urandom};
    exp_b = ref_sel(data, 2, N4);
    drive(1'b1, 2'd2);
    cyc();
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_hold_a", dout, exp_a);
    data = {$urandom, $urandom, $urandom, $urandom};
    drive(1'b1, 2'd3);
    cyc();
    check("bp_still_a", dout, exp_a);
    check("bp_still_full", 32'(in_ready), 32'd0);
    drive(1'b0, 2'd0);
    out_ready = 1'b1;
    cyc();
    check("bp_ready_back", 32'(in_ready), 32'd1);
    check("bp_b_next", dout, exp_b);
    cyc();
    check("bp_drained", 32'(out_valid), 32'd0);
    check("bp_data_holds", dout, exp_b);
    out_ready = 1'b0;

    // Reset while FULL discards both held beats.
    drive(1'b1, 2'd0);
    cyc();
    drive(1'b1, 2'd3);
    cyc();
    drive(1'b0, 2'd0);
    check("full_before_rst", 32'(in_ready), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_data", dout, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    #1 rst = 1'b0;
    out_ready = 1'b1;
    cyc();
    check("no_stale_beat", 32'(out_valid), 32'd0);
    data  = {$urandom, $urandom, $urandom, $urandom};
    exp_c = ref_sel(data, 2, N4);
    drive(1'b1, 2'd2);
    cyc();
    check("c_first", dout, exp_c);
    drive(1'b0, 2'd0);
    cyc();

    // Randomised valid/ready traffic.
    sent  = 0;
    cyc_n = 0;
    while (sent < 1000 && cyc_n < 20000) begin
      data      = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 2) != 0);
      v         = ($urandom_range(0, 3) != 0);
      s         = 2'($urandom_range(0, 3));
      if (v && in_ready) sent++;
      drive(v, s);
      cyc();
      cyc_n++;
    end
    check("random_sent", 32'(sent), 32'd1000);
    drive(1'b0, 2'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      cyc();
    end
    cyc();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(out_valid), 32'd0);

    // Out-of-range select on the 3-input instance.
    data3     = {32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    in_valid3 = 1'b1;
    sel3      = 2'd1;
    cyc();
    check("oor_in_range", dout3, ref_sel({32'h0, data3}, 1, N3));
`ifdef MUX_SEL_ERR_EN
    check("oor_err_clear", 32'(sel_err3), 32'd0);
`endif
    sel3 = 2'd3;
    cyc();
    in_valid3 = 1'b0;
    check("oor_valid", 32'(out_valid3), 32'd1);
    check("oor_zero", dout3, ref_sel({32'h0, data3}, 3, N3));
`ifdef MUX_SEL_ERR_EN
    check("oor_err_set", 32'(sel_err3), 32'd1);
    cyc();
    cyc();
    check("oor_err_sticky", 32'(sel_err3), 32'd1);
    check("pow2_err_tied", 32'(sel_err), 32'd0);
    #1 rst = 1'b1;
    #1;
    check("oor_err_rst", 32'(sel_err3), 32'd0);
    #1 rst = 1'b0;
`endif
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
- Parametrised N:1 data selector with a registered, flow-controlled output stage.
- Successor to the fixed 3:1 combinational selector used on the datapath.
- Generalises input count and width; adds valid/ready handshake, a skid buffer for full throughput under back-pressure, and defined out-of-range select handling.
- Sits between pipeline stages wherever an operand/forwarding choice must be registered before the next stage consumes it.

Parameters:
- DATA_W, 32, width of each data input and of the output.
- NUM_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, clog2(NUM_IN), select width; derived, not overridden.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_i  in  NUM_IN*DATA_W  packed inputs; input k occupies bits [k*DATA_W +: DATA_W].
- select_i  in  SEL_W  index of the input to forward.
- in_valid_i  in  1  data_i/select_i valid this cycle.
- in_ready_o  out  1  stage can accept a beat.
- data_o  out  DATA_W  registered selected data.
- out_valid_o  out  1  data_o valid.
- out_ready_i  in  1  downstream accepts data_o.

Behaviour:
- Reset (async assert, sync release): out_valid_o=0, data_o=0, skid empty, in_ready_o=1.
- Input transfer when in_valid_i && in_ready_o. Output transfer when out_valid_o && out_ready_i.
- Selection is combinational on the input side: sel_data = input[select_i] if select_i < NUM_IN, else all zeros.
- Latency: a beat accepted at edge n appears on data_o with out_valid_o=1 after edge n; one cycle. Throughput is one beat per cycle while out_ready_i=1.
- Storage: main output register plus one skid register.
- in_ready_o = !skid_valid. It is registered and has no combinational path from out_ready_i.
- States (skid_valid, out_valid): EMPTY(0,0), ONE(0,1), FULL(1,1).
- EMPTY:
  - accept -> ONE.
- ONE:
  - accept with no output transfer -> FULL; the new beat goes to the skid register.
  - accept with output transfer -> ONE; the main register is reloaded.
  - output transfer only -> EMPTY.
- FULL:
  - no accept possible.
  - output transfer -> ONE; skid data moves to the main register.
- data_o and out_valid_o are stable while out_valid_o=1 and out_ready_i=0; no overwrite or drop.
- data_o holds its last value when out_valid_o=0. It is not cleared except by reset.
- Reset asserted mid-operation discards all held beats immediately. No partial transfer completes.
- select_i and data_i are ignored when in_valid_i=0 or in_ready_o=0.
- Ordering is strictly FIFO; no beat is duplicated or lost.

Optional Feature:
- Macro MUX_SEL_ERR_EN.
- When defined:
  - adds port sel_err_o (out, 1), a sticky flag.
  - sel_err_o is set on the edge after a transfer accepted with select_i >= NUM_IN.
  - sel_err_o is cleared only by rst_i; reset value 0.
  - Data behaviour is unchanged: zeros are forwarded.
- When undefined:
  - the port is absent.
  - out-of-range select silently forwards zeros.
- When NUM_IN is a power of two, sel_err_o is tied to 0.

Decomposition:
- Package mux_pkg:
  - clog2 helper function used to derive SEL_W.
  - NUM_IN_MAX=16 constant.
  - enum for skid states EMPTY/ONE/FULL.
- Sub-module pipe_skid_buf(DATA_W):
  - generic two-entry valid/ready register stage.
  - the top instantiates it after the combinational selector.
  - reusable by other pipeline stages.

Test Plan:
- Reset check: assert rst_i asynchronously between edges -> out_valid_o=0, data_o=0, in_ready_o=1 immediately, before the next edge.
- Streaming:
  - stimulus: NUM_IN=4, DATA_W=32, data_i={D3..D0}=0x33/0x22/0x11/0x00, select_i sequence 2,0,3,1, in_valid_i=1 and out_ready_i=1 every cycle.
  - response: data_o = 0x22,0x00,0x33,0x11 on consecutive cycles, each one cycle after acceptance.
- Back-pressure:
  - stimulus: out_ready_i=0 while sending beats A then B.
  - response: in_ready_o drops to 0 after B; data_o=A is held stable.
  - stimulus: raise out_ready_i for 2 cycles.
  - response: A then B emitted; in_ready_o returns to 1 after the first drain.
- Out-of-range select:
  - stimulus: NUM_IN=3, select_i=3 with valid.
  - response: data_o=0. With MUX_SEL_ERR_EN, sel_err_o=1 from the next edge until reset.
- Reset mid-flight:
  - stimulus: put the stage in FULL, then pulse rst_i.
  - response: out_valid_o=0; no stale beat appears after release; next accepted beat C emerges first.
- Randomised valid/ready toggling over 1000 beats against a scoreboard -> output sequence equals input-selected sequence; no loss or duplication.
